// File: rtl/multi_channel_queue.sv
// Multi-channel queue: NUM_CH independent circular FIFOs merged onto one
// read port through a round-robin arbiter that holds its grant under backpressure.

module mcq_channel #(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = 3,
    parameter int CW        = 3,
    parameter int PW        = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic                 flush,
    output logic [DATA_SIZE-1:0] head,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 afull
);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic                 wr_ok;
    logic                 rd_ok;

    // Local guards keep the counter from wrapping even if the caller misbehaves.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                mem[wptr] <= wr_data;
                wptr      <= (wptr == LAST) ? '0 : wptr + PW'(1);
            end
            if (rd_ok) rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == FULLC);
    assign empty = (count == '0);
    assign afull = (count >= CW'(AFULL_TH));
endmodule

module multi_channel_queue #(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 4,
    parameter int NUM_CH    = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH),
    localparam int CHW      = $clog2(NUM_CH)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [NUM_CH-1:0]           wr_valid_i,
    output logic [NUM_CH-1:0]           wr_ready_o,
    input  logic [NUM_CH*DATA_SIZE-1:0] wr_data_i,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [DATA_SIZE-1:0]        rd_data_o,
    output logic [CHW-1:0]              rd_ch_o,
    input  logic [NUM_CH-1:0]           flush_i,
    output logic [NUM_CH-1:0]           afull_o,
    output logic [NUM_CH*CW-1:0]        count_o
);
    logic [NUM_CH-1:0][DATA_SIZE-1:0] head;
    logic [NUM_CH-1:0][CW-1:0]        cnt;
    logic [NUM_CH-1:0]                full;
    logic [NUM_CH-1:0]                empty;
    logic [NUM_CH-1:0]                wr_en;
    logic [NUM_CH-1:0]                rd_en;
    logic [CHW-1:0]                   last_served;
    logic [CHW-1:0]                   lock_ch;
    logic                             lock_vld;
    logic [CHW-1:0]                   rr_ch;
    logic [CHW-1:0]                   grant;
    logic                             rd_fire;

    assign wr_ready_o = ~full & {NUM_CH{rstn_i}};
    assign wr_en      = wr_valid_i & wr_ready_o & ~flush_i;
    assign rd_valid_o = |(~empty);
    assign rd_fire    = rd_valid_o & rd_ready_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign rd_en[c] = rd_fire && (grant == CHW'(c));
        assign count_o[c*CW +: CW] = cnt[c];

        mcq_channel #(
            .DATA_SIZE (DATA_SIZE),
            .DEPTH     (DEPTH),
            .AFULL_TH  (AFULL_TH),
            .CW        (CW),
            .PW        (PW)
        ) u_ch (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .wr_en   (wr_en[c]),
            .wr_data (wr_data_i[c*DATA_SIZE +: DATA_SIZE]),
            .rd_en   (rd_en[c]),
            .flush   (flush_i[c]),
            .head    (head[c]),
            .count   (cnt[c]),
            .full    (full[c]),
            .empty   (empty[c]),
            .afull   (afull_o[c])
        );
    end

    // Walk downward so the closest non-empty channel after last_served wins.
    always_comb begin
        int idx;
        idx   = 0;
        rr_ch = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last_served) + i) % NUM_CH;
            if (!empty[CHW'(idx)]) rr_ch = CHW'(idx);
        end
    end

    assign grant     = lock_vld ? lock_ch : rr_ch;
    assign rd_ch_o   = grant;
    assign rd_data_o = head[grant];

    // A stalled grant is held; flushing the held channel drops the hold and its read.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_vld    <= 1'b0;
            lock_ch     <= '0;
            last_served <= CHW'(NUM_CH - 1);
        end else begin
            lock_vld <= rd_valid_o & ~rd_ready_i & ~flush_i[grant];
            lock_ch  <= grant;
            if (rd_fire && !flush_i[grant]) last_served <= grant;
        end
    end
endmodule

// File: tb/tb_multi_channel_queue.sv
// Bench for multi_channel_queue: vector table for one channel, directed sequences
// for arbitration/lock/flush/reset, and a per-channel scoreboard checked every cycle.

module tb_multi_channel_queue;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int NCH   = 4;
    localparam int AF    = DEPTH - 1;
    localparam int CW    = 3;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NCH-1:0]    wr_valid;
    logic [NCH-1:0]    wr_ready;
    logic [NCH*DW-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DW-1:0]     rd_data;
    logic [1:0]        rd_ch;
    logic [NCH-1:0]    flush;
    logic [NCH-1:0]    afull;
    logic [NCH*CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q [NCH][$];
    logic          lk_vld = 1'b0;
    logic [1:0]    lk_ch;
    logic [DW-1:0] lk_data;

    always #5 clk = ~clk;

    multi_channel_queue #(.DATA_SIZE(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_data_i  (wr_data),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .rd_ch_o    (rd_ch),
        .flush_i    (flush),
        .afull_o    (afull),
        .count_o    (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_afull"}, afull, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_rd_ch"}, rd_ch, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    // Scoreboard: state is compared against the model, then the upcoming edge is applied.
    always @(negedge clk) begin
        int       sz [NCH];
        logic     any;
        logic [DW-1:0] exp_d;
        if (!rstn) for (int c = 0; c < NCH; c++) q[c].delete();
        any = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            sz[c] = q[c].size();
            if (sz[c] != 0) any = 1'b1;
            check("sb_count", count[c*CW +: CW], sz[c]);
            check("sb_wr_ready", wr_ready[c], rstn && (sz[c] != DEPTH));
            check("sb_afull", afull[c], sz[c] >= AF);
        end
        check("sb_rd_valid", rd_valid, any);
        if (rstn && lk_vld) begin
            check("lock_ch", rd_ch, lk_ch);
            check("lock_data", rd_data, lk_data);
        end
        lk_vld  = rstn && rd_valid && !rd_ready && !flush[rd_ch];
        lk_ch   = rd_ch;
        lk_data = rd_data;
        if (rstn) begin
            if (rd_valid && rd_ready && !flush[rd_ch]) begin
                if (q[rd_ch].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL read_empty: channel %0d read with model empty", rd_ch);
                end else begin
                    exp_d = q[rd_ch].pop_front();
                    check("sb_rd_data", rd_data, exp_d);
                end
            end
            for (int c = 0; c < NCH; c++)
                if (wr_valid[c] && !flush[c] && sz[c] != DEPTH) q[c].push_back(wr_data[c*DW +: DW]);
            for (int c = 0; c < NCH; c++)
                if (flush[c]) q[c].delete();
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ptr
        always @(negedge clk) begin
            if (rstn) begin
                check("wptr_range", {63'b0, dut.g_ch[g].u_ch.wptr >= DEPTH}, 0);
                check("rptr_range", {63'b0, dut.g_ch[g].u_ch.rptr >= DEPTH}, 0);
            end
        end
    end

    typedef struct {
        logic          wv;
        logic [DW-1:0] d;
        logic          rr;
        logic          e_rv;
        logic [DW-1:0] e_rd;
        logic          e_wrdy;
        logic          e_af;
        logic [CW-1:0] e_cnt;
    } vec_t;

    initial begin
        vec_t tbl [9];
        tbl[0] = '{1'b1, 16'hA1, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 3'd1};
        tbl[1] = '{1'b1, 16'hA2, 1'b0, 1'b1, 16'hA1, 1'b1, 1'b0, 3'd2};
        tbl[2] = '{1'b1, 16'hA3, 1'b0, 1'b1, 16'hA1, 1'b1, 1'b1, 3'd3};
        tbl[3] = '{1'b1, 16'hA4, 1'b0, 1'b1, 16'hA1, 1'b0, 1'b1, 3'd4};
        tbl[4] = '{1'b1, 16'hA5, 1'b0, 1'b1, 16'hA1, 1'b0, 1'b1, 3'd4};
        tbl[5] = '{1'b0, 16'h00, 1'b1, 1'b1, 16'hA1, 1'b1, 1'b1, 3'd3};
        tbl[6] = '{1'b0, 16'h00, 1'b1, 1'b1, 16'hA2, 1'b1, 1'b0, 3'd2};
        tbl[7] = '{1'b0, 16'h00, 1'b1, 1'b1, 16'hA3, 1'b1, 1'b0, 3'd1};
        tbl[8] = '{1'b0, 16'h00, 1'b1, 1'b1, 16'hA4, 1'b1, 1'b0, 3'd0};

        wr_valid = '0;
        wr_data  = '0;
        rd_ready = 1'b0;
        flush    = '0;
        #2;
        check_reset_outputs("reset");
        step();
        step();
        rstn = 1'b1;
        #1;
        check("post_reset_wr_ready", wr_ready, 4'hF);

        // Single channel fill to full, refused fifth write, drain in order
        for (int i = 0; i < 9; i++) begin
            wr_valid = {3'b0, tbl[i].wv};
            wr_data  = {48'b0, tbl[i].d};
            rd_ready = tbl[i].rr;
            check("t1_rd_valid", rd_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                check("t1_rd_data", rd_data, tbl[i].e_rd);
                check("t1_rd_ch", rd_ch, 0);
            end
            step();
            check("t1_wr_ready0", wr_ready[0], tbl[i].e_wrdy);
            check("t1_afull0", afull[0], tbl[i].e_af);
            check("t1_count0", count[CW-1:0], tbl[i].e_cnt);
        end
        wr_valid = '0;
        rd_ready = 1'b0;

        // Round-robin over four preloaded channels
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wr_valid = 4'hF;
            for (int c = 0; c < NCH; c++) wr_data[c*DW +: DW] = 16'((c << 8) | k);
            step();
        end
        wr_valid = '0;
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_rd_ch", rd_ch, i % 4);
            check("t2_rd_data", rd_data, ((i % 4) << 8) | (i / 4));
            step();
        end
        rd_ready = 1'b0;
        check("t2_drained", rd_valid, 0);

        // Grant held under backpressure while another channel fills
        do_reset();
        wr_valid = 4'b0100;
        wr_data[2*DW +: DW] = 16'h55;
        step();
        wr_valid = 4'b0001;
        wr_data[0 +: DW] = 16'h77;
        check("t3_ch_a", rd_ch, 2);
        check("t3_data_a", rd_data, 16'h55);
        step();
        wr_valid = '0;
        check("t3_ch_b", rd_ch, 2);
        check("t3_data_b", rd_data, 16'h55);
        step();
        check("t3_ch_c", rd_ch, 2);
        rd_ready = 1'b1;
        check("t3_data_c", rd_data, 16'h55);
        step();
        check("t3_next_ch", rd_ch, 0);
        check("t3_next_data", rd_data, 16'h77);
        step();
        rd_ready = 1'b0;
        check("t3_empty", rd_valid, 0);

        // Flush of a full channel beats a same-cycle write
        wr_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            wr_data[DW +: DW] = 16'(16'h100 + k);
            step();
        end
        wr_valid = '0;
        check("t4_full_count", count[CW +: CW], 4);
        check("t4_full_ready", wr_ready[1], 0);
        flush = 4'b0010;
        wr_valid = 4'b0010;
        wr_data[DW +: DW] = 16'hDEAD;
        step();
        flush = '0;
        wr_valid = '0;
        check("t4_flush_count", count[CW +: CW], 0);
        check("t4_flush_ready", wr_ready[1], 1);
        check("t4_flush_valid", rd_valid, 0);
        wr_valid = 4'b0010;
        wr_data[DW +: DW] = 16'hBEEF;
        step();
        wr_valid = '0;
        rd_ready = 1'b1;
        check("t4_after_flush", rd_data, 16'hBEEF);
        step();
        rd_ready = 1'b0;

        // Full channel: simultaneous read and write refuses the write
        wr_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            wr_data[0 +: DW] = 16'(16'h10 + k);
            step();
        end
        rd_ready = 1'b1;
        wr_data[0 +: DW] = 16'h14;
        check("t5_ready_full", wr_ready[0], 0);
        check("t5_rd_ch", rd_ch, 0);
        check("t5_rd_data", rd_data, 16'h10);
        step();
        check("t5_count_a", count[CW-1:0], 3);
        check("t5_ready_a", wr_ready[0], 1);
        check("t5_rd_data_b", rd_data, 16'h11);
        step();
        check("t5_count_b", count[CW-1:0], 3);
        wr_valid = '0;
        for (int k = 0; k < 3; k++) step();
        rd_ready = 1'b0;
        check("t5_drained", count[CW-1:0], 0);

        // Asynchronous reset pulse with three channels occupied
        wr_valid = 4'b1011;
        for (int c = 0; c < NCH; c++) wr_data[c*DW +: DW] = 16'(16'h60 + c);
        step();
        step();
        wr_valid = '0;
        check("t6_loaded", count, {3'd2, 3'd0, 3'd2, 3'd2});
        #1;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        step();
        rstn = 1'b1;
        check("t6_no_stale", rd_valid, 0);
        wr_valid = 4'b0011;
        wr_data[0 +: DW]  = 16'h70;
        wr_data[DW +: DW] = 16'h71;
        step();
        wr_valid = '0;
        rd_ready = 1'b1;
        check("t6_first_ch", rd_ch, 0);
        check("t6_first_data", rd_data, 16'h70);
        step();
        check("t6_second_ch", rd_ch, 1);
        check("t6_second_data", rd_data, 16'h71);
        step();
        rd_ready = 1'b0;
        check("t6_empty", rd_valid, 0);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_channel_queue.md
MULTI_CHANNEL_QUEUE -- requirements
Module: multi_channel_queue

Interface
REQ-001 Parameter DATA_SIZE, default 16, payload width in bits.
REQ-002 Parameter DEPTH, default 4, entries per channel, >=2, not required to be a power of two.
REQ-003 Parameter NUM_CH, default 4, number of independent write channels, >=2.
REQ-004 Parameter AFULL_TH, default DEPTH-1, per-channel almost-full threshold, 1..DEPTH.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 rstn_i  input  1  reset, asynchronous, active-low.
REQ-007 wr_valid_i  input  NUM_CH  per-channel write request.
REQ-008 wr_ready_o  output  NUM_CH  per-channel space available.
REQ-009 wr_data_i  input  NUM_CH*DATA_SIZE  channel c payload in bits [c*DATA_SIZE +: DATA_SIZE].
REQ-010 rd_valid_o  output  1  merged output holds a valid entry.
REQ-011 rd_ready_i  input  1  consumer accepts the output.
REQ-012 rd_data_o  output  DATA_SIZE  head entry of the granted channel.
REQ-013 rd_ch_o  output  clog2(NUM_CH)  index of the granted channel.
REQ-014 flush_i  input  NUM_CH  per-channel synchronous flush.
REQ-015 afull_o  output  NUM_CH  per-channel count >= AFULL_TH.
REQ-016 count_o  output  NUM_CH*clog2(DEPTH+1)  per-channel occupancy, same packing as wr_data_i.

Function
REQ-017 Each channel SHALL be an independent circular FIFO with its own write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-018 wr_ready_o[c] SHALL equal (count[c] != DEPTH) and rstn_i, and SHALL NOT depend on wr_valid_i or flush_i.
REQ-019 Write on c SHALL occur when wr_valid_i[c] and wr_ready_o[c] are high and flush_i[c] is low; the entry is visible at the head on the next cycle, minimum write-to-read latency 1 cycle.
REQ-020 rd_valid_o SHALL be high whenever any channel is non-empty; rd_data_o and rd_ch_o SHALL reflect the granted channel's head combinationally.
REQ-021 Arbitration SHALL be round-robin: search starts at channel (last_served+1) mod NUM_CH and grants the first non-empty channel; last_served resets to NUM_CH-1, so channel 0 has first priority.
REQ-022 When rd_valid_o is high and rd_ready_i is low, the grant SHALL be locked: rd_ch_o and rd_data_o stay unchanged until acceptance, even if other channels receive data.
REQ-023 A read occurs when rd_valid_o and rd_ready_i are high; the granted channel's read pointer advances, and last_served updates to that channel.
REQ-024 Simultaneous write and read on one channel SHALL leave its count unchanged; a full channel accepts no write that cycle, even if it is being read. wr_ready_o is based on registered count only.
REQ-025 flush_i[c] SHALL, on the next edge, zero count, write pointer and read pointer of c. It overrides any write or read to c in the same cycle. Storage contents need not be cleared.
REQ-026 If the locked channel is flushed, the lock SHALL release. The read in that cycle is discarded, and last_served is not updated.
REQ-027 Count arithmetic SHALL be clog2(DEPTH+1) bits and never overflow or underflow; afull_o and count_o derive from registered counts.

Reset
REQ-028 While rstn_i is low: all counts, pointers and the lock are zero; last_served = NUM_CH-1; wr_ready_o = 0, rd_valid_o = 0, afull_o = 0, count_o = 0, rd_ch_o = 0. Storage SHALL be zeroed, so rd_data_o = 0.
REQ-029 Reset asserted mid-transfer SHALL discard all queued entries immediately. The first post-reset grant goes to channel 0 if non-empty.
REQ-030 Under ASSERTION, the bench SHALL check every cycle that no write occurs when full, no read occurs when empty, all pointers stay < DEPTH, all counts stay <= DEPTH, and the locked rd_ch_o/rd_data_o stay stable while rd_valid_o=1 and rd_ready_i=0.

Verification
REQ-031 Defaults, write 0xA1,0xA2,0xA3,0xA4 on ch0, then a 5th with rd_ready_i=0 -> wr_ready_o[0]=0 after the 4th, afull_o[0]=1 after the 3rd; reads return A1..A4 in order, rd_ch_o=0.
REQ-032 Preload ch0..ch3 with 2 entries each, rd_ready_i=1 continuously -> rd_ch_o sequence 0,1,2,3,0,1,2,3, with each channel's data in FIFO order.
REQ-033 ch2 holds 0x55, rd_ready_i=0, then write ch0 -> rd_ch_o stays 2 and rd_data_o stays 0x55 until rd_ready_i=1; the next grant is 3 if non-empty, else 0.
REQ-034 ch1 full, flush_i[1]=1 with wr_valid_i[1]=1 in the same cycle -> count_o[1]=0 and wr_ready_o[1]=1 the next cycle; the written word is not stored.
REQ-035 ch0 full, with simultaneous read (granted) and write on ch0 -> read accepted, write refused, count becomes 3; the next cycle, write accepted together with the next read.
REQ-036 rstn_i pulsed low for 1 cycle with entries in 3 channels -> all outputs are at reset values asynchronously, and no stale data is read after release.
